reg_hazard_ctrl: RTL and testbench

Pipeline hazard scheduler for the 16-bit core's decode/register stage. Tracks in-flight register writes in a shift-register scoreboard mirroring the EX→MEM→WB stages. Decides each cycle whether the decoded instruction may issue into the register read/write stage, must stall (RAW hazard on a pending destination), or must be squashed after a taken branch. Sits between the control unit/decoder and the register read/write stage, and drives the fetch hold and bubble-insert controls.

---
 rtl/reg_hazard_ctrl_if.sv | 43 ++++
 rtl/reg_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_reg_hazard_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_hazard_ctrl_if
//  Description : Decode-side handshake bundle for the register hazard
//                scheduler.
//                Decode inputs : valid, rd1/rd2 address + used flags,
//                                write enable + address, branch taken.
//                Results       : issue, stall, bubble, pending mask,
//                                registered state, stall counter.
//                master = decoder/control side, slave = hazard scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_hazard_ctrl_if;
  logic       i_1_id_valid;
  logic [3:0] i_4_id_rd1_addr;
  logic [3:0] i_4_id_rd2_addr;
  logic       i_1_id_rd1_used;
  logic       i_1_id_rd2_used;
  logic       i_1_id_wr_en;
  logic [3:0] i_4_id_wr_addr;
  logic       i_1_branch_taken;
  logic        o_1_issue;
  logic        o_1_stall;
  logic        o_1_bubble;
  logic [15:0] o_16_pending;
  logic [1:0]  or_2_state;
  logic [7:0]  or_8_stall_cnt;

  modport master (
    output i_1_id_valid, i_4_id_rd1_addr, i_4_id_rd2_addr, i_1_id_rd1_used,
           i_1_id_rd2_used, i_1_id_wr_en, i_4_id_wr_addr, i_1_branch_taken,
    input  o_1_issue, o_1_stall, o_1_bubble, o_16_pending, or_2_state,
           or_8_stall_cnt
  );

  modport slave (
    input  i_1_id_valid, i_4_id_rd1_addr, i_4_id_rd2_addr, i_1_id_rd1_used,
           i_1_id_rd2_used, i_1_id_wr_en, i_4_id_wr_addr, i_1_branch_taken,
    output o_1_issue, o_1_stall, o_1_bubble, o_16_pending, or_2_state,
           or_8_stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/reg_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : reg_hazard_ctrl
//  Description : Decode/register-stage hazard scheduler for the 16-bit core.
//                A shift-register scoreboard mirrors the EX..WB stages and
//                records in-flight destination registers. Each cycle the
//                decoded instruction issues, stalls on a RAW hazard, or is
//                squashed while a taken branch flushes the front end.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                bus (slave)    - decode inputs and issue/stall/bubble,
//                                 pending mask, state, stall counter
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_hazard_ctrl #(
  parameter int PIPE_DEPTH   = 3,
  parameter int WB_BYPASS    = 0,
  parameter int FLUSH_CYCLES = 2
) (
  input  wire logic         clk,
  input  wire logic         rst,
  reg_hazard_ctrl_if.slave  bus
);

  // With a write-through register file the WB entry is already visible to
  // the read port, so it is excluded from the hazard check.
  localparam int         c_nchk       = (WB_BYPASS != 0) ? PIPE_DEPTH - 1 : PIPE_DEPTH;
  localparam logic [1:0] c_flush_load = 2'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  logic [PIPE_DEPTH-1:0] sb_valid_q, sb_valid_d;
  logic [3:0]            sb_addr_q [PIPE_DEPTH];
  logic [3:0]            sb_addr_d [PIPE_DEPTH];
  state_t                state_q, state_d;
  logic [1:0]            flush_cnt_q, flush_cnt_d;
  logic [7:0]            stall_cnt_q, stall_cnt_d;

  logic        w_rd1_hit;
  logic        w_rd2_hit;
  logic        w_hazard;
  logic        w_flush_now;
  logic        w_issue;
  logic        w_stall;
  logic [15:0] w_pending;

  // Scoreboard lookup and pending mask
  always_comb begin
    w_rd1_hit = 1'b0;
    w_rd2_hit = 1'b0;
    w_pending = '0;
    for (int i = 0; i < c_nchk; i++) begin
      if (sb_valid_q[i] && (sb_addr_q[i] == bus.i_4_id_rd1_addr)) w_rd1_hit = 1'b1;
      if (sb_valid_q[i] && (sb_addr_q[i] == bus.i_4_id_rd2_addr)) w_rd2_hit = 1'b1;
    end
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      if (sb_valid_q[i]) w_pending[sb_addr_q[i]] = 1'b1;
    end
  end

  assign w_hazard    = bus.i_1_id_valid &
                       ((bus.i_1_id_rd1_used & w_rd1_hit) | (bus.i_1_id_rd2_used & w_rd2_hit));
  assign w_flush_now = bus.i_1_branch_taken | (state_q == ST_FLUSH);
  // Reset forces a bubble regardless of decode contents.
  assign w_issue     = ~rst & bus.i_1_id_valid & ~w_hazard & ~w_flush_now;
  assign w_stall     = ~rst & w_hazard & ~w_flush_now;

  // Scoreboard shift: a stall or squash enters as an invalid entry
  always_comb begin
    sb_valid_d   = {sb_valid_q[PIPE_DEPTH-2:0], w_issue & bus.i_1_id_wr_en};
    sb_addr_d[0] = bus.i_4_id_wr_addr;
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      sb_addr_d[i] = sb_addr_q[i-1];
    end
  end

  // State machine and flush counter. The counter holds the number of FLUSH
  // cycles still to run including the current one; the branch cycle is the
  // first squashed slot, so FLUSH_CYCLES-1 FLUSH cycles follow it.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.i_1_branch_taken) begin
      if (FLUSH_CYCLES > 1) begin
        state_d     = ST_FLUSH;
        flush_cnt_d = c_flush_load;
      end else begin
        // A single squashed slot is fully covered by the branch cycle.
        state_d     = ST_RUN;
        flush_cnt_d = 2'd0;
      end
    end else if ((state_q == ST_FLUSH) && (flush_cnt_q > 2'd1)) begin
      flush_cnt_d = flush_cnt_q - 2'd1;
    end else begin
      flush_cnt_d = 2'd0;
      state_d     = w_hazard ? ST_STALL : ST_RUN;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (w_stall && (stall_cnt_q != 8'hFF)) stall_cnt_d = stall_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_valid_q  <= '0;
      state_q     <= ST_RUN;
      flush_cnt_q <= 2'd0;
      stall_cnt_q <= 8'd0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        sb_addr_q[i] <= 4'd0;
      end
    end else begin
      sb_valid_q  <= sb_valid_d;
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        sb_addr_q[i] <= sb_addr_d[i];
      end
    end
  end

  assign bus.o_1_issue      = w_issue;
  assign bus.o_1_stall      = w_stall;
  assign bus.o_1_bubble     = ~w_issue;
  assign bus.o_16_pending   = w_pending;
  assign bus.or_2_state     = state_q;
  assign bus.or_8_stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_hazard_ctrl
//  Description : Self-checking bench for reg_hazard_ctrl. Two instances
//                (defaults, and WB_BYPASS=1 / FLUSH_CYCLES=3) share one
//                stimulus stream; a timestamp-based reference model predicts
//                every output each cycle, and directed phases pin literals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       d_valid, d_u1, d_u2, d_we, d_br;
  logic [3:0] d_a1, d_a2, d_wa;

  reg_hazard_ctrl_if bus0 ();
  reg_hazard_ctrl_if bus1 ();

  assign bus0.i_1_id_valid = d_valid;  assign bus1.i_1_id_valid = d_valid;
  assign bus0.i_4_id_rd1_addr = d_a1;  assign bus1.i_4_id_rd1_addr = d_a1;
  assign bus0.i_4_id_rd2_addr = d_a2;  assign bus1.i_4_id_rd2_addr = d_a2;
  assign bus0.i_1_id_rd1_used = d_u1;  assign bus1.i_1_id_rd1_used = d_u1;
  assign bus0.i_1_id_rd2_used = d_u2;  assign bus1.i_1_id_rd2_used = d_u2;
  assign bus0.i_1_id_wr_en = d_we;     assign bus1.i_1_id_wr_en = d_we;
  assign bus0.i_4_id_wr_addr = d_wa;   assign bus1.i_4_id_wr_addr = d_wa;
  assign bus0.i_1_branch_taken = d_br; assign bus1.i_1_branch_taken = d_br;

  reg_hazard_ctrl #(.PIPE_DEPTH(3), .WB_BYPASS(0), .FLUSH_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  reg_hazard_ctrl #(.PIPE_DEPTH(3), .WB_BYPASS(1), .FLUSH_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each register remembers the cycle of its latest issued write; it is
  // pending for PD cycles after that and hazardous for PD (or PD-1) cycles.
  localparam int M_PD [2] = '{3, 3};
  localparam int M_BY [2] = '{0, 1};
  localparam int M_FC [2] = '{2, 3};

  int m_last [2][16];
  int m_sq_end [2];
  int m_cnt [2];
  int m_state [2];
  int cyc = 0;

  task automatic m_reset(input int d);
    for (int r = 0; r < 16; r++) m_last[d][r] = -1000;
    m_sq_end[d] = -1000;
    m_cnt[d]    = 0;
    m_state[d]  = 0;
  endtask

  task automatic m_step(input int d, input logic a_iss, input logic a_stl,
                        input logic a_bub, input logic [15:0] a_pend,
                        input logic [1:0] a_st, input logic [7:0] a_cnt);
    int          w, age1, age2, age;
    bit          haz, fl, iss, stl;
    logic [15:0] pend;
    w    = (M_BY[d] != 0) ? M_PD[d] - 1 : M_PD[d];
    pend = '0;
    for (int r = 0; r < 16; r++) begin
      age = cyc - m_last[d][r];
      if (age >= 1 && age <= M_PD[d]) pend[r] = 1'b1;
    end
    age1 = cyc - m_last[d][d_a1];
    age2 = cyc - m_last[d][d_a2];
    haz  = d_valid && ((d_u1 && age1 >= 1 && age1 <= w) || (d_u2 && age2 >= 1 && age2 <= w));
    fl   = d_br || (cyc <= m_sq_end[d]);
    iss  = !rst && d_valid && !haz && !fl;
    stl  = !rst && haz && !fl;
    chk($sformatf("dut%0d issue", d), 32'(a_iss), 32'(iss));
    chk($sformatf("dut%0d stall", d), 32'(a_stl), 32'(stl));
    chk($sformatf("dut%0d bubble", d), 32'(a_bub), 32'(!iss));
    chk($sformatf("dut%0d pending", d), 32'(a_pend), 32'(pend));
    chk($sformatf("dut%0d state", d), 32'(a_st), 32'(m_state[d]));
    chk($sformatf("dut%0d stall_cnt", d), 32'(a_cnt), 32'(m_cnt[d]));
    if (rst) begin
      m_reset(d);
    end else begin
      if (iss && d_we) m_last[d][d_wa] = cyc;
      if (stl && m_cnt[d] < 255) m_cnt[d]++;
      if (d_br) m_sq_end[d] = cyc + M_FC[d] - 1;
      if (cyc + 1 <= m_sq_end[d]) m_state[d] = 2;
      else if (d_br)              m_state[d] = 0;
      else                        m_state[d] = haz ? 1 : 0;
    end
  endtask

  initial begin
    m_reset(0);
    m_reset(1);
    forever begin
      @(negedge clk);
      m_step(0, bus0.o_1_issue, bus0.o_1_stall, bus0.o_1_bubble, bus0.o_16_pending,
             bus0.or_2_state, bus0.or_8_stall_cnt);
      m_step(1, bus1.o_1_issue, bus1.o_1_stall, bus1.o_1_bubble, bus1.o_16_pending,
             bus1.or_2_state, bus1.or_8_stall_cnt);
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  logic held = 1'b0;

  task automatic tick();
    @(negedge clk);
    held = bus0.o_1_stall | bus1.o_1_stall;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_valid = 0; d_we = 0; d_u1 = 0; d_u2 = 0; d_br = 0;
    d_a1 = 0; d_a2 = 0; d_wa = 0;
  endtask

  task automatic instr(input logic we, input logic [3:0] wa, input logic u1,
                       input logic [3:0] a1, input logic u2, input logic [3:0] a2);
    d_valid = 1; d_we = we; d_wa = wa; d_u1 = u1; d_a1 = a1; d_u2 = u2; d_a2 = a2;
  endtask

  task automatic rst_pulse();
    rst = 1; idle(); tick(); rst = 0;
  endtask

  initial begin
    int n0, n1;
    rst = 1;
    idle();
    // Reset with a valid instruction presented
    instr(1, 5, 1, 1, 1, 2);
    tick(); tick();
    #1;
    chk("rst issue", 32'(bus0.o_1_issue), 0);
    chk("rst bubble", 32'(bus0.o_1_bubble), 1);
    chk("rst state", 32'(bus0.or_2_state), 0);
    chk("rst pending", 32'(bus0.o_16_pending), 0);
    chk("rst cnt", 32'(bus0.or_8_stall_cnt), 0);
    rst = 0;

    // Independent stream r1, r2, r3 each reading r4
    instr(1, 1, 1, 4, 0, 0); #1; chk("ind issue1", 32'(bus0.o_1_issue), 1); tick();
    instr(1, 2, 1, 4, 0, 0); #1; chk("ind issue2", 32'(bus0.o_1_issue), 1); tick();
    instr(1, 3, 1, 4, 0, 0); #1; chk("ind issue3", 32'(bus0.o_1_issue), 1); tick();
    idle(); #1;
    chk("ind pending", 32'(bus0.o_16_pending), 32'h000E);
    repeat (4) tick();

    // RAW on r3
    rst_pulse();
    instr(1, 3, 0, 0, 0, 0); #1; chk("raw write issue", 32'(bus0.o_1_issue), 1); tick();
    instr(0, 0, 1, 3, 0, 0);
    n0 = 0; n1 = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      n1 += int'(bus1.o_1_stall);
      if (bus0.o_1_issue) break;
      n0 += int'(bus0.o_1_stall);
      tick();
    end
    chk("raw stall len dut0", 32'(n0), 3);
    chk("raw stall len dut1", 32'(n1), 2);
    tick(); idle(); #1;
    chk("raw cnt dut0", 32'(bus0.or_8_stall_cnt), 3);
    chk("raw cnt dut1", 32'(bus1.or_8_stall_cnt), 2);

    // Unused operand
    rst_pulse();
    instr(1, 3, 0, 0, 0, 0); tick();
    instr(0, 0, 1, 5, 0, 3); #1;
    chk("unused issue", 32'(bus0.o_1_issue), 1);
    chk("unused stall", 32'(bus0.o_1_stall), 0);

    // Branch over a hazard
    rst_pulse();
    instr(1, 3, 0, 0, 0, 0); tick();
    instr(0, 0, 1, 3, 0, 0); d_br = 1; #1;
    chk("br issue", 32'(bus0.o_1_issue), 0);
    chk("br stall", 32'(bus0.o_1_stall), 0);
    chk("br pending", 32'(bus0.o_16_pending), 32'h0008);
    tick(); d_br = 0; #1;
    chk("flush issue", 32'(bus0.o_1_issue), 0);
    chk("flush stall", 32'(bus0.o_1_stall), 0);
    chk("flush state", 32'(bus0.or_2_state), 2);
    tick(); #1;
    chk("post flush state", 32'(bus0.or_2_state), 1);
    chk("post flush stall", 32'(bus0.o_1_stall), 1);
    chk("post flush pending", 32'(bus0.o_16_pending), 32'h0008);
    tick(); idle(); #1;
    chk("retired pending", 32'(bus0.o_16_pending), 0);

    // Back-to-back branches extend the squash
    rst_pulse();
    instr(0, 0, 1, 7, 0, 0); d_br = 1; #1; chk("dbr c0", 32'(bus0.o_1_issue), 0);
    tick(); #1; chk("dbr c1", 32'(bus0.o_1_issue), 0);
    tick(); d_br = 0; #1;
    chk("dbr c2", 32'(bus0.o_1_issue), 0);
    chk("dbr c2 state", 32'(bus0.or_2_state), 2);
    tick(); #1; chk("dbr c3", 32'(bus0.o_1_issue), 1);

    // Saturation: ~330 stall cycles on dut0
    rst_pulse();
    for (int j = 0; j < 110; j++) begin
      instr(1, 3, 0, 0, 0, 0); tick();
      instr(0, 0, 1, 3, 0, 0);
      for (int k = 0; k < 10; k++) begin
        #1;
        if (bus0.o_1_issue) break;
        tick();
      end
      tick();
    end
    idle(); #1;
    chk("sat cnt", 32'(bus0.or_8_stall_cnt), 255);

    // Reset in the middle of a stall
    instr(1, 3, 0, 0, 0, 0); tick();
    instr(0, 0, 1, 3, 0, 0); #1;
    chk("pre-rst stall", 32'(bus0.o_1_stall), 1);
    rst = 1; tick(); rst = 0; idle(); #1;
    chk("mid rst pending", 32'(bus0.o_16_pending), 0);
    chk("mid rst state", 32'(bus0.or_2_state), 0);
    chk("mid rst cnt", 32'(bus0.or_8_stall_cnt), 0);

    // Randomized traffic; decode inputs held while either instance stalls
    for (int n = 0; n < 3000; n++) begin
      if (!held) begin
        d_valid = ($urandom_range(0, 9) < 8);
        d_a1    = 4'($urandom_range(0, 5));
        d_a2    = 4'($urandom_range(0, 5));
        d_u1    = 1'($urandom_range(0, 1));
        d_u2    = 1'($urandom_range(0, 1));
        d_we    = ($urandom_range(0, 9) < 7);
        d_wa    = 4'($urandom_range(0, 5));
      end
      d_br = ($urandom_range(0, 11) == 0);
      rst  = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 0;
    idle();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
